// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg
// Shared types and constants for the pipeline stall/flush control logic.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

`default_nettype wire

// File: rtl/hazard_control_unit_sat_counter.sv
// ============================================================================
// sat_counter
// Event counter that holds at its all-ones value instead of wrapping.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// ============================================================================
// hazard_control_unit
// ID-stage stall/flush controller: load-use, taken-branch and memory-wait.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_control_unit #(
    parameter int FLUSH_CYCLES   = 1,
    parameter int STORE_DATA_FWD = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_uses_rs1,
    input  logic             IF_ID_uses_rs2,
    input  logic             IF_ID_is_store,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_mem_read,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             PC_write_en,
    output logic             IF_ID_write_en,
    output logic             ID_EX_write_en,
    output logic             EX_MEM_write_en,
    output logic             ID_EX_bubble,
    output logic             IF_ID_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    import pipe_ctrl_pkg::*;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t     state_q,      state_d;
    state_t     resume_q,     resume_d;
    state_t     eff_state;
    logic [2:0] flush_left_q, flush_left_d;
    logic       stall_inc;
    logic       flush_inc;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       load_use;

    // A stall parked in MEM_WAIT behaves like the state it will resume into.
    assign eff_state = (state_q == MEM_WAIT) ? resume_q : state_q;

    assign rs1_hit  = IF_ID_uses_rs1 && (IF_ID_rs1 == ID_EX_rd);
    assign rs2_hit  = IF_ID_uses_rs2 && (IF_ID_rs2 == ID_EX_rd)
                      && !((STORE_DATA_FWD != 0) && IF_ID_is_store);
    assign load_use = ID_EX_mem_read && (ID_EX_rd != REG_X0) && (rs1_hit || rs2_hit);

    always_comb begin
        PC_write_en     = 1'b1;
        IF_ID_write_en  = 1'b1;
        ID_EX_write_en  = 1'b1;
        EX_MEM_write_en = 1'b1;
        ID_EX_bubble    = 1'b0;
        IF_ID_flush     = 1'b0;
        state_d         = state_q;
        resume_d        = resume_q;
        flush_left_d    = flush_left_q;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;

        if (mem_busy) begin
            // Branch in EX is frozen along with everything else and re-presents later.
            PC_write_en     = 1'b0;
            IF_ID_write_en  = 1'b0;
            ID_EX_write_en  = 1'b0;
            EX_MEM_write_en = 1'b0;
            state_d         = MEM_WAIT;
            resume_d        = eff_state;
            stall_inc       = 1'b1;
        end else if (branch_taken && (eff_state == RUN)) begin
            ID_EX_bubble = 1'b1;
            IF_ID_flush  = 1'b1;
            flush_inc    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d      = FLUSH;
                flush_left_d = FLUSH_INIT;
            end else begin
                state_d      = RUN;
                flush_left_d = 3'd0;
            end
        end else if (eff_state == FLUSH) begin
            ID_EX_bubble = 1'b1;
            IF_ID_flush  = 1'b1;
            if (flush_left_q <= 3'd1) begin
                state_d      = RUN;
                flush_left_d = 3'd0;
            end else begin
                state_d      = FLUSH;
                flush_left_d = flush_left_q - 3'd1;
            end
        end else if (load_use) begin
            PC_write_en    = 1'b0;
            IF_ID_write_en = 1'b0;
            ID_EX_bubble   = 1'b1;
            stall_inc      = 1'b1;
            state_d        = RUN;
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            resume_q     <= RUN;
            flush_left_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            resume_q     <= resume_d;
            flush_left_q <= flush_left_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
// tb_hazard_control_unit
// Scoreboard bench: two configurations driven with directed vectors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_control_unit;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       st;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       busy;
    } in_t;

    typedef struct {
        bit          sel;
        logic [5:0]  o;
        logic [15:0] sc;
        logic [15:0] fc;
        string       nm;
    } exp_t;

    // Output vector order: {PC, IF_ID, ID_EX, EX_MEM write enables, bubble, flush}
    localparam logic [5:0] ALL = 6'b111100;
    localparam logic [5:0] STL = 6'b001110;
    localparam logic [5:0] FL  = 6'b111111;
    localparam logic [5:0] BSY = 6'b000000;

    logic clk = 1'b0;
    logic reset;
    in_t  in_a, in_b;

    logic        a_pc, a_ifid, a_idex, a_exmem, a_bub, a_fl;
    logic [15:0] a_sc, a_fc;
    logic        b_pc, b_ifid, b_idex, b_exmem, b_bub, b_fl;
    logic [1:0]  b_sc, b_fc;

    exp_t sb[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.FLUSH_CYCLES(2), .STORE_DATA_FWD(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset),
        .IF_ID_rs1(in_a.rs1), .IF_ID_rs2(in_a.rs2),
        .IF_ID_uses_rs1(in_a.u1), .IF_ID_uses_rs2(in_a.u2), .IF_ID_is_store(in_a.st),
        .ID_EX_rd(in_a.rd), .ID_EX_mem_read(in_a.mr),
        .branch_taken(in_a.br), .mem_busy(in_a.busy),
        .PC_write_en(a_pc), .IF_ID_write_en(a_ifid), .ID_EX_write_en(a_idex),
        .EX_MEM_write_en(a_exmem), .ID_EX_bubble(a_bub), .IF_ID_flush(a_fl),
        .stall_count(a_sc), .flush_count(a_fc)
    );

    hazard_control_unit #(.FLUSH_CYCLES(1), .STORE_DATA_FWD(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset),
        .IF_ID_rs1(in_b.rs1), .IF_ID_rs2(in_b.rs2),
        .IF_ID_uses_rs1(in_b.u1), .IF_ID_uses_rs2(in_b.u2), .IF_ID_is_store(in_b.st),
        .ID_EX_rd(in_b.rd), .ID_EX_mem_read(in_b.mr),
        .branch_taken(in_b.br), .mem_busy(in_b.busy),
        .PC_write_en(b_pc), .IF_ID_write_en(b_ifid), .ID_EX_write_en(b_idex),
        .EX_MEM_write_en(b_exmem), .ID_EX_bubble(b_bub), .IF_ID_flush(b_fl),
        .stall_count(b_sc), .flush_count(b_fc)
    );

    function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic st,
                               input logic [4:0] rd, input logic mr,
                               input logic br, input logic busy);
        in_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.st = st;
        v.rd = rd; v.mr = mr; v.br = br; v.busy = busy;
        return v;
    endfunction

    task automatic push(input bit sel, input logic [5:0] e, input int sc, input int fc,
                        input string nm);
        exp_t x;
        x.sel = sel; x.o = e; x.sc = 16'(sc); x.fc = 16'(fc); x.nm = nm;
        sb.push_back(x);
    endtask

    // Apply one vector just after a rising edge; counters expected are pre-increment.
    task automatic vec(input bit sel, input in_t v, input logic [5:0] e,
                       input int sc, input int fc, input string nm);
        @(posedge clk);
        #1;
        if (sel) begin
            in_b = v;
            in_a = '0;
        end else begin
            in_a = v;
            in_b = '0;
        end
        push(sel, e, sc, fc, nm);
    endtask

    // Monitor: outputs are combinational, so each cycle's response is sampled at negedge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            logic [5:0]  act_o;
            logic [15:0] act_sc, act_fc;
            cur    = sb.pop_front();
            act_o  = cur.sel ? {b_pc, b_ifid, b_idex, b_exmem, b_bub, b_fl}
                             : {a_pc, a_ifid, a_idex, a_exmem, a_bub, a_fl};
            act_sc = cur.sel ? {14'd0, b_sc} : a_sc;
            act_fc = cur.sel ? {14'd0, b_fc} : a_fc;
            n_cmp++;
            if (act_o !== cur.o) begin
                n_bad++;
                $display("FAIL %s outs: got %b expected %b", cur.nm, act_o, cur.o);
            end
            n_cmp++;
            if (act_sc !== cur.sc) begin
                n_bad++;
                $display("FAIL %s stall_count: got %0d expected %0d", cur.nm, act_sc, cur.sc);
            end
            n_cmp++;
            if (act_fc !== cur.fc) begin
                n_bad++;
                $display("FAIL %s flush_count: got %0d expected %0d", cur.nm, act_fc, cur.fc);
            end
        end
    end

    initial begin
        in_t idle;
        in_t lu_rs1;
        in_t br_only;
        in_t busy;
        in_t br_busy;
        idle    = '0;
        lu_rs1  = mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        br_only = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        busy    = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        br_busy = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

        reset = 1'b1;
        in_a  = '0;
        in_b  = '0;
        push(1'b0, ALL, 0, 0, "reset_a");
        @(negedge clk);
        #1;
        push(1'b1, ALL, 0, 0, "reset_b");
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Config B: no store-data forwarding, single flush cycle, 2-bit counters
        vec(1'b1, mk(5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0), STL, 0, 0, "b_store_nofwd");
        vec(1'b1, idle,    ALL, 1, 0, "b_after_stall");
        vec(1'b1, br_only, FL,  1, 0, "b_branch");
        vec(1'b1, idle,    ALL, 1, 1, "b_after_branch");
        vec(1'b1, busy,    BSY, 1, 1, "b_busy1");
        vec(1'b1, busy,    BSY, 2, 1, "b_busy2");
        vec(1'b1, busy,    BSY, 3, 1, "b_busy3_sat");
        vec(1'b1, busy,    BSY, 3, 1, "b_busy4_sat");
        vec(1'b1, idle,    ALL, 3, 1, "b_saturated");

        // Config A: two flush cycles, store-data forwarding on
        vec(1'b0, idle,    ALL, 0, 0, "a_idle");
        vec(1'b0, lu_rs1,  STL, 0, 0, "a_loaduse_rs1");
        vec(1'b0, mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0), ALL, 1, 0, "a_loaduse_clear");
        vec(1'b0, mk(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), ALL, 1, 0, "a_x0");
        vec(1'b0, mk(5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0), ALL, 1, 0, "a_store_fwd");
        vec(1'b0, mk(5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0), STL, 1, 0, "a_loaduse_rs2");
        vec(1'b0, idle,    ALL, 2, 0, "a_idle2");
        vec(1'b0, mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0), FL, 2, 0, "a_branch_lu");
        vec(1'b0, idle,    FL,  2, 1, "a_flush2");
        vec(1'b0, idle,    ALL, 2, 1, "a_run_after_flush");
        vec(1'b0, br_only, FL,  2, 1, "a_branch2");
        vec(1'b0, busy,    BSY, 2, 2, "a_flush_busy1");
        vec(1'b0, busy,    BSY, 3, 2, "a_flush_busy2");
        vec(1'b0, busy,    BSY, 4, 2, "a_flush_busy3");
        vec(1'b0, idle,    FL,  5, 2, "a_flush_resume");
        vec(1'b0, idle,    ALL, 5, 2, "a_run_after_resume");
        vec(1'b0, br_busy, BSY, 5, 2, "a_br_busy1");
        vec(1'b0, br_busy, BSY, 6, 2, "a_br_busy2");
        vec(1'b0, br_only, FL,  7, 2, "a_br_accept");
        vec(1'b0, idle,    FL,  7, 3, "a_br_flush2");
        vec(1'b0, idle,    ALL, 7, 3, "a_run3");
        vec(1'b0, br_only, FL,  7, 3, "a_branch3");

        // Asynchronous reset in the middle of the second flush cycle
        @(posedge clk);
        #1;
        in_a = idle;
        #2;
        reset = 1'b1;
        push(1'b0, ALL, 0, 0, "a_async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        vec(1'b0, idle,    ALL, 0, 0, "a_after_reset");
        vec(1'b0, busy,    BSY, 0, 0, "a_busy_then_lu");
        vec(1'b0, lu_rs1,  STL, 1, 0, "a_lu_from_memwait");
        vec(1'b0, idle,    ALL, 2, 0, "a_final");

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
